iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001: The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 8..64, power of two).
REQ-002: The module SHALL have parameter MULDIV_EN, default 1; when 1, the iterative multiply and divide ops are implemented.
REQ-003: The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004: The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005: The module SHALL have port in_valid, input, 1 bit: the operand/op bundle is valid.
REQ-006: The module SHALL have port in_ready, output, 1 bit: the block can accept a bundle.
REQ-007: The module SHALL have port A, input, WIDTH bits: first operand.
REQ-008: The module SHALL have port B, input, WIDTH bits: second operand.
REQ-009: The module SHALL have port sel, input, 4 bits: operation select.
REQ-010: The module SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011: The module SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012: The module SHALL have port result, output, WIDTH bits: operation result.
REQ-013: The module SHALL have port zero, output, 1 bit: asserted when result is all zeros, qualified by out_valid.

Function
REQ-014: A bundle SHALL be accepted on a rising edge where in_valid && in_ready; A, B and sel SHALL be captured only on acceptance.
REQ-015: sel encoding SHALL be: 0 ADD, 1 SUB, 2 OR, 3 XOR, 4 AND, 5 SLTU, 6 SLT (signed), 7 SLL, 8 SRL, 9 SRA, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU; 14, 15 and any multiply/divide op with MULDIV_EN=0 SHALL execute as ADD.
REQ-016: ADD/SUB SHALL wrap modulo 2^WIDTH; SLTU/SLT SHALL return 1 or 0 zero-extended to WIDTH.
REQ-017: Shift ops SHALL use only B[log2(WIDTH)-1:0] as the shift amount; SRA SHALL replicate A[WIDTH-1].
REQ-018: The FSM SHALL have the states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019: On acceptance of ops 0-9, 14, 15 (or a divide with B=0), the FSM SHALL go IDLE->DONE, so out_valid rises on the next edge, giving a latency of 1.
REQ-020: On acceptance of ops 10-13 with a legal operand, the FSM SHALL go IDLE->BUSY and iterate one bit per cycle for exactly WIDTH cycles, then go BUSY->DONE; out_valid is then first high WIDTH+1 edges after acceptance.
REQ-021: Multiply SHALL be an unsigned shift-add over a 2*WIDTH-bit product register.
REQ-022: Divide SHALL be an unsigned restoring divide yielding the quotient and remainder together.
REQ-023: DIVU with B=0 SHALL return all ones; REMU with B=0 SHALL return A; both with latency 1.
REQ-024: In DONE, result and zero SHALL hold stable until out_ready=1; on that edge the FSM SHALL go to IDLE and out_valid SHALL fall.
REQ-025: A new bundle SHALL NOT be accepted in the same cycle as the result handoff; the next acceptance is earliest one cycle later.
REQ-026: in_valid, A, B and sel changing while in BUSY or DONE SHALL have no effect on the operation in flight.
REQ-027: result SHALL read 0 whenever out_valid=0.

Reset
REQ-028: When rst_n=0, the block SHALL immediately go to IDLE, independent of clk, with in_ready=1, out_valid=0, result=0, zero=0 and all iteration registers cleared.
REQ-029: Reset asserted in BUSY or DONE SHALL abort the operation with no result delivered; after rst_n rises, the first acceptance SHALL behave as from power-up.

Verification
REQ-030: The bench SHALL cover this case: WIDTH=32, ADD with A=0xFFFFFFFF, B=1, out_ready=1 -> out_valid one cycle later, result=0x00000000, zero=1.
REQ-031: The bench SHALL cover this case: SRA with A=0x80000000, B=0x00000024 -> result=0xF8000000 (shift of 4), latency 1.
REQ-032: The bench SHALL cover this case: MULHU with A=B=0xFFFFFFFF -> out_valid 33 cycles after acceptance, result=0xFFFFFFFE; MUL on the same operands -> 0x00000001.
REQ-033: The bench SHALL cover this case: DIVU with A=100, B=7 -> 14 after 33 cycles; REMU with the same operands -> 2; DIVU with B=0 -> 0xFFFFFFFF and REMU with B=0 -> 100, both with latency 1.
REQ-034: The bench SHALL cover this case: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0, and a new in_valid is ignored until one cycle after the handoff.
REQ-035: The bench SHALL cover this case: rst_n pulsed low at cycle 10 of a DIVU -> out_valid=0 and in_ready=1 asynchronously; a following ADD of 2+3 -> 5.

Source files
------------

// File: rtl/iter_alu.sv
// iter_alu: valid/ready ALU, 1-cycle ops plus WIDTH-cycle shift-add multiply / restoring divide; ports clk rst_n in_valid in_ready A B sel out_valid out_ready result zero
module iter_alu #(
    parameter int WIDTH     = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int SW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     res;
    logic [WIDTH-1:0]     quick;
    logic [SW-1:0]        cnt;
    logic [SW-1:0]        sa;
    logic [3:0]           op;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       rsh;
    logic [WIDTH+1:0]     diff;
    logic                 hi;
    logic                 dv;
    logic                 slow;

    assign op   = (sel > 4'd13 || (MULDIV_EN == 0 && sel > 4'd9)) ? 4'd0 : sel;
    assign sa   = B[SW-1:0];
    assign slow = op >= 4'd10 && !(op[2] && B == '0);

    always_comb begin
        quick = A + B;
        case (op)
            4'd1:    quick = A - B;
            4'd2:    quick = A | B;
            4'd3:    quick = A ^ B;
            4'd4:    quick = A & B;
            4'd5:    quick = {{(WIDTH-1){1'b0}}, A < B};
            4'd6:    quick = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'd7:    quick = A << sa;
            4'd8:    quick = A >> sa;
            4'd9:    quick = $unsigned($signed(A) >>> sa);
            4'd12:   quick = '1;
            4'd13:   quick = A;
            default: quick = A + B;
        endcase
    end

    // acc holds {hi product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign rsh    = acc[2*WIDTH-1:WIDTH-1];
    assign diff   = {1'b0, rsh} - {2'b0, opb};
    assign acc_nx = !dv ? {sum, acc[WIDTH-1:1]} :
                    diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} :
                    {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign result    = res;
    assign zero      = out_valid && res == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            opb   <= '0;
            res   <= '0;
            cnt   <= '0;
            hi    <= 1'b0;
            dv    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (slow) begin
                        state <= BUSY;
                        acc   <= {{WIDTH{1'b0}}, A};
                        opb   <= B;
                        hi    <= op[0];
                        dv    <= op[2];
                        cnt   <= '0;
                    end else begin
                        state <= DONE;
                        res   <= quick;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == SW'(WIDTH-1)) begin
                        state <= DONE;
                        res   <= hi ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
                    end
                end
                DONE: if (out_ready) begin
                    state <= IDLE;
                    res   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: randomized self-checking bench for iter_alu against an arithmetic reference model
module tb_iter_alu;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        out_ready = 0;
    logic [31:0] A = 0;
    logic [31:0] B = 0;
    logic [3:0]  sel = 0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    int          passed = 0;
    int          total = 0;

    iter_alu #(.WIDTH(32), .MULDIV_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        logic [63:0] p;
        logic [31:0] r;
        p = {32'b0, a} * {32'b0, b};
        case (s)
            4'd1:    r = a - b;
            4'd2:    r = a | b;
            4'd3:    r = a ^ b;
            4'd4:    r = a & b;
            4'd5:    r = (a < b) ? 32'd1 : 32'd0;
            4'd6:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    r = a << b[4:0];
            4'd8:    r = a >> b[4:0];
            4'd9:    r = $signed(a) >>> b[4:0];
            4'd10:   r = p[31:0];
            4'd11:   r = p[63:32];
            4'd12:   r = (b == 0) ? 32'hFFFFFFFF : a / b;
            4'd13:   r = (b == 0) ? a : a % b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [31:0] b, input logic [3:0] s);
        if (s >= 4'd10 && s <= 4'd13 && !(s >= 4'd12 && b == 0)) return 33;
        return 1;
    endfunction

    // called at #1 after a rising edge; returns the delivered result and edges from acceptance to out_valid
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                          output logic [31:0] r, output logic z, output int lat);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        A = a; B = b; sel = s; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; A = $urandom; B = $urandom; sel = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = result; z = zero;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else passed++;
        total++; if (zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", zero); else passed++;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_wrap();
        logic [31:0] r; logic z; int lat;
        out_ready = 1;
        run_op(32'hFFFFFFFF, 32'h1, 4'd0, r, z, lat);
        total++; if (r !== 32'h0) $display("FAIL add_wrap_result: got %h want 00000000", r); else passed++;
        total++; if (z !== 1'b1) $display("FAIL add_wrap_zero: got %b want 1", z); else passed++;
        total++; if (lat != 1) $display("FAIL add_wrap_latency: got %0d want 1", lat); else passed++;
    endtask

    task automatic test_sra();
        logic [31:0] r; logic z; int lat;
        run_op(32'h80000000, 32'h24, 4'd9, r, z, lat);
        total++; if (r !== 32'hF8000000) $display("FAIL sra_result: got %h want f8000000", r); else passed++;
        total++; if (lat != 1) $display("FAIL sra_latency: got %0d want 1", lat); else passed++;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic z; int lat;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd11, r, z, lat);
        total++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu_result: got %h want fffffffe", r); else passed++;
        total++; if (lat != 33) $display("FAIL mulhu_latency: got %0d want 33", lat); else passed++;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd10, r, z, lat);
        total++; if (r !== 32'h1) $display("FAIL mul_result: got %h want 00000001", r); else passed++;
        total++; if (lat != 33) $display("FAIL mul_latency: got %0d want 33", lat); else passed++;
    endtask

    task automatic test_div();
        logic [31:0] r; logic z; int lat;
        run_op(32'd100, 32'd7, 4'd12, r, z, lat);
        total++; if (r !== 32'd14) $display("FAIL divu_result: got %0d want 14", r); else passed++;
        total++; if (lat != 33) $display("FAIL divu_latency: got %0d want 33", lat); else passed++;
        run_op(32'd100, 32'd7, 4'd13, r, z, lat);
        total++; if (r !== 32'd2) $display("FAIL remu_result: got %0d want 2", r); else passed++;
        run_op(32'd100, 32'd0, 4'd12, r, z, lat);
        total++; if (r !== 32'hFFFFFFFF) $display("FAIL divu0_result: got %h want ffffffff", r); else passed++;
        total++; if (lat != 1) $display("FAIL divu0_latency: got %0d want 1", lat); else passed++;
        run_op(32'd100, 32'd0, 4'd13, r, z, lat);
        total++; if (r !== 32'd100) $display("FAIL remu0_result: got %0d want 100", r); else passed++;
        total++; if (lat != 1) $display("FAIL remu0_latency: got %0d want 1", lat); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, pa, pb, held;
        int w = 0;
        a = $urandom; b = $urandom; pa = $urandom; pb = $urandom;
        A = a; B = b; sel = 4'd3; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1; w++;
        end
        held = result;
        total++; if (held !== model(a, b, 4'd3)) $display("FAIL bp_initial: got %h want %h", held, model(a, b, 4'd3)); else passed++;
        A = pa; B = pb; sel = 4'd0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (result !== held) $display("FAIL bp_stable_%0d: got %h want %h", i, result, held); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); else passed++;
            total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid_%0d: got %b want 1", i, out_valid); else passed++;
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_handoff_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_handoff_ready: got %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || result !== pa + pb)
            $display("FAIL bp_next_op: valid %b result %h want valid 1 result %h", out_valid, result, pa + pb);
        else passed++;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] r; logic z; int lat;
        int seen = 0;
        A = 32'd100; B = 32'd7; sel = 4'd12; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (result !== 32'h0) $display("FAIL rst_mid_result: got %h want 0", result); else passed++;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen != 0) $display("FAIL rst_mid_no_result: got %0d valid cycles want 0", seen); else passed++;
        run_op(32'd2, 32'd3, 4'd0, r, z, lat);
        total++; if (r !== 32'd5) $display("FAIL rst_after_add: got %0d want 5", r); else passed++;
        total++; if (lat != 1) $display("FAIL rst_after_latency: got %0d want 1", lat); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, e; logic [3:0] s; logic z; int lat;
        for (int i = 0; i < 60; i++) begin
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 1) ? 32'($urandom_range(1, 255)) : $urandom);
            e = model(a, b, s);
            run_op(a, b, s, r, z, lat);
            total++; if (r !== e) $display("FAIL rand_%0d_sel%0d_result: got %h want %h (a=%h b=%h)", i, s, r, e, a, b); else passed++;
            total++; if (z !== (e == 0)) $display("FAIL rand_%0d_zero: got %b want %b", i, z, e == 0); else passed++;
            total++; if (lat != exp_lat(b, s)) $display("FAIL rand_%0d_latency: got %0d want %0d", i, lat, exp_lat(b, s)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sra();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
